// File: rtl/brightness_ramp.sv
// Slew-rate limiter: walks value_o toward the latest target by STEP_SIZE once
// every CLOCK_FREQ_MHZ * STEP_PERIOD_US cycles, reporting busy and a done pulse.
module brightness_ramp #(
    parameter int CLOCK_FREQ_MHZ = 100,
    parameter int STEP_PERIOD_US = 20,
    parameter int VALUE_SIZE     = 8,
    parameter int STEP_SIZE      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [VALUE_SIZE-1:0] target_i,
    input  logic                  target_valid_i,
    output logic [VALUE_SIZE-1:0] value_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int US_W = (CLOCK_FREQ_MHZ > 1) ? $clog2(CLOCK_FREQ_MHZ) : 1;
    localparam int ST_W = (STEP_PERIOD_US > 1) ? $clog2(STEP_PERIOD_US) : 1;
    localparam logic [VALUE_SIZE:0] STEP = (VALUE_SIZE+1)'(STEP_SIZE);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                state;
    logic [US_W-1:0]       us_cnt;
    logic [ST_W-1:0]       step_cnt;
    logic [VALUE_SIZE-1:0] tgt_q;
    logic [VALUE_SIZE-1:0] eff_tgt;
    logic [VALUE_SIZE:0]   up_diff;
    logic [VALUE_SIZE:0]   down_diff;
    logic                  us_wrap;
    logic                  step_wrap;
    logic                  step_tick;

    // A strobe arriving with a tick steps toward the new target, not the stored one.
    always_comb begin
        eff_tgt   = target_valid_i ? target_i : tgt_q;
        up_diff   = {1'b0, eff_tgt} - {1'b0, value_o};
        down_diff = {1'b0, value_o} - {1'b0, eff_tgt};
        us_wrap   = (us_cnt == US_W'(CLOCK_FREQ_MHZ - 1));
        step_wrap = (step_cnt == ST_W'(STEP_PERIOD_US - 1));
        step_tick = us_wrap && step_wrap && (state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            value_o  <= '0;
            tgt_q    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            us_cnt   <= '0;
            step_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            if (target_valid_i) tgt_q <= target_i;

            if (state == IDLE) begin
                us_cnt   <= '0;
                step_cnt <= '0;
            end else begin
                us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
                if (us_wrap) step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (target_valid_i && (target_i != value_o)) begin
                        state  <= (target_i > value_o) ? UP : DOWN;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    // Direction is re-derived every cycle so a retarget can flip it.
                    if (eff_tgt == value_o) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        us_cnt   <= '0;
                        step_cnt <= '0;
                    end else if (eff_tgt > value_o) begin
                        state <= UP;
                        if (step_tick) begin
                            if (up_diff <= STEP) begin
                                value_o  <= eff_tgt;
                                state    <= IDLE;
                                busy_o   <= 1'b0;
                                done_o   <= 1'b1;
                                us_cnt   <= '0;
                                step_cnt <= '0;
                            end else begin
                                value_o <= value_o + STEP[VALUE_SIZE-1:0];
                            end
                        end
                    end else begin
                        state <= DOWN;
                        if (step_tick) begin
                            if (down_diff <= STEP) begin
                                value_o  <= eff_tgt;
                                state    <= IDLE;
                                busy_o   <= 1'b0;
                                done_o   <= 1'b1;
                                us_cnt   <= '0;
                                step_cnt <= '0;
                            end else begin
                                value_o <= value_o - STEP[VALUE_SIZE-1:0];
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_brightness_ramp.sv
// Directed bench for brightness_ramp with N = 2 MHz * 3 us = 6 cycles per step.
module tb_brightness_ramp;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] t1 = '0, t4 = '0;
    logic       v1 = 1'b0, v4 = 1'b0;
    logic [7:0] val1, val4;
    logic       busy1, busy4, done1, done4;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    brightness_ramp #(.CLOCK_FREQ_MHZ(2), .STEP_PERIOD_US(3), .VALUE_SIZE(8), .STEP_SIZE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .target_i(t1), .target_valid_i(v1),
        .value_o(val1), .busy_o(busy1), .done_o(done1));

    brightness_ramp #(.CLOCK_FREQ_MHZ(2), .STEP_PERIOD_US(3), .VALUE_SIZE(8), .STEP_SIZE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .target_i(t4), .target_valid_i(v4),
        .value_o(val4), .busy_o(busy4), .done_o(done4));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        cyc(); cyc();
        n_cmp++;
        if ({val1, busy1, done1} !== 10'd0) begin
            n_bad++; $display("FAIL reset_dut1: got %0d/%b/%b want 0/0/0", val1, busy1, done1);
        end
        n_cmp++;
        if ({val4, busy4, done4} !== 10'd0) begin
            n_bad++; $display("FAIL reset_dut4: got %0d/%b/%b want 0/0/0", val4, busy4, done4);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (done1 || done4 || busy1 || busy4 || val1 != 0 || val4 != 0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++; $display("FAIL idle_quiet: activity seen=%b want 0", bad);
        end
    endtask

    task automatic test_ramp_step1();
        logic [7:0] ev;
        t1 = 8'd5; v1 = 1'b1;
        cyc();
        v1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1 || val1 !== 8'd0 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL ramp5_capture: busy=%b val=%0d done=%b want 1/0/0", busy1, val1, done1);
        end
        for (int j = 1; j <= 30; j++) begin
            cyc();
            ev = 8'(j / 6);
            n_cmp++;
            if (val1 !== ev || busy1 !== (j < 30) || done1 !== (j == 30)) begin
                n_bad++;
                $display("FAIL ramp5_E+%0d: val=%0d busy=%b done=%b want %0d/%b/%b",
                         j, val1, busy1, done1, ev, (j < 30), (j == 30));
            end
        end
        cyc();
        n_cmp++;
        if (done1 !== 1'b0) begin
            n_bad++; $display("FAIL ramp5_done_width: done=%b want 0", done1);
        end
    endtask

    task automatic wait_done4(input string nm, input logic [7:0] want);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            cyc();
            if (done4) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || val4 !== want) begin
            n_bad++; $display("FAIL %s: seen=%b val=%0d want 1/%0d", nm, seen, val4, want);
        end
    endtask

    task automatic test_step4();
        logic [7:0] ev;
        logic [7:0] dn [0:3];
        dn[0] = 8'd10; dn[1] = 8'd6; dn[2] = 8'd2; dn[3] = 8'd0;
        t4 = 8'd250; v4 = 1'b1; cyc(); v4 = 1'b0;
        wait_done4("step4_reach250", 8'd250);
        t4 = 8'd255; v4 = 1'b1; cyc(); v4 = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            ev = (j < 6) ? 8'd250 : (j < 12) ? 8'd254 : 8'd255;
            n_cmp++;
            if (val4 !== ev || done4 !== (j == 12)) begin
                n_bad++; $display("FAIL up255_E+%0d: val=%0d done=%b want %0d/%b", j, val4, done4, ev, (j == 12));
            end
        end
        t4 = 8'd10; v4 = 1'b1; cyc(); v4 = 1'b0;
        wait_done4("step4_reach10", 8'd10);
        t4 = 8'd0; v4 = 1'b1; cyc(); v4 = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            cyc();
            ev = dn[j / 6];
            n_cmp++;
            if (val4 !== ev || done4 !== (j == 18) || busy4 !== (j < 18)) begin
                n_bad++;
                $display("FAIL down0_E+%0d: val=%0d done=%b busy=%b want %0d/%b/%b",
                         j, val4, done4, busy4, ev, (j == 18), (j < 18));
            end
        end
    endtask

    task automatic test_retarget();
        int pulses;
        rst = 1'b1; cyc(); rst = 1'b0;
        t1 = 8'd200; v1 = 1'b1; cyc(); v1 = 1'b0;
        repeat (18) cyc();
        n_cmp++;
        if (val1 !== 8'd3) begin
            n_bad++; $display("FAIL retarget_pre: val=%0d want 3", val1);
        end
        t1 = 8'd1; v1 = 1'b1; cyc(); v1 = 1'b0;
        n_cmp++;
        if (val1 !== 8'd3 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL retarget_edge: val=%0d busy=%b done=%b want 3/1/0", val1, busy1, done1);
        end
        pulses = 0;
        for (int j = 20; j <= 36; j++) begin
            cyc();
            if (done1) pulses++;
            if (j == 23 || j == 24 || j == 29 || j == 30) begin
                n_cmp++;
                if (val1 !== ((j < 24) ? 8'd3 : (j < 30) ? 8'd2 : 8'd1) || done1 !== (j == 30)) begin
                    n_bad++; $display("FAIL retarget_E+%0d: val=%0d done=%b", j, val1, done1);
                end
            end
        end
        n_cmp++;
        if (pulses !== 1 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL retarget_pulses: pulses=%0d busy=%b want 1/0", pulses, busy1);
        end
    endtask

    task automatic test_equal_and_reset();
        logic bad;
        t1 = val1; v1 = 1'b1; cyc(); v1 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy1 || done1 || val1 !== 8'd1) bad = 1'b1;
            cyc();
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++; $display("FAIL equal_target: activity=%b want 0", bad);
        end
        t1 = 8'd50; v1 = 1'b1; cyc(); v1 = 1'b0;
        repeat (8) cyc();
        n_cmp++;
        if (val1 !== 8'd2 || busy1 !== 1'b1) begin
            n_bad++; $display("FAIL midramp: val=%0d busy=%b want 2/1", val1, busy1);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++;
        if (val1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL midramp_reset: val=%0d busy=%b done=%b want 0/0/0", val1, busy1, done1);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (busy1 || done1 || val1 !== 8'd0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_quiet: activity=%b want 0", bad);
        end
    endtask

    task automatic test_simultaneous();
        t1 = 8'd20; v1 = 1'b1; cyc(); v1 = 1'b0;
        repeat (65) cyc();
        n_cmp++;
        if (val1 !== 8'd10) begin
            n_bad++; $display("FAIL simul_pre: val=%0d want 10", val1);
        end
        t1 = 8'd12; v1 = 1'b1; cyc(); v1 = 1'b0;
        n_cmp++;
        if (val1 !== 8'd11 || busy1 !== 1'b1) begin
            n_bad++; $display("FAIL simul_edge: val=%0d busy=%b want 11/1", val1, busy1);
        end
        repeat (5) cyc();
        n_cmp++;
        if (val1 !== 8'd11 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL simul_E+71: val=%0d done=%b want 11/0", val1, done1);
        end
        cyc();
        n_cmp++;
        if (val1 !== 8'd12 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL simul_E+72: val=%0d done=%b busy=%b want 12/1/0", val1, done1, busy1);
        end
        repeat (12) cyc();
        n_cmp++;
        if (val1 !== 8'd12 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL simul_hold: val=%0d busy=%b want 12/0", val1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_step1();
        test_step4();
        test_retarget();
        test_equal_and_reset();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/brightness_ramp.md
# brightness_ramp

Slew-rate limiter between the brightness accumulator and the PWM generator. It accepts a target duty value and moves its output toward that target by a fixed step once per programmable time interval. Large jumps from the rotary encoder therefore become smooth fades on the LEDs. It reports ramp progress with a busy level and a one-cycle done pulse.

## Interface
Parameters:
- CLOCK_FREQ_MHZ, 100: clock frequency in MHz, 1..655; sets the microsecond prescaler.
- STEP_PERIOD_US, 20: microseconds between steps, ≥1.
- VALUE_SIZE, 8: width of target and output duty values.
- STEP_SIZE, 1: increment per step, 1..2^VALUE_SIZE-1.

Ports (clock and reset first):
- clk_i, input, 1: sole clock; all logic on rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- target_i, input, VALUE_SIZE: requested duty value.
- target_valid_i, input, 1: single-cycle strobe that captures target_i. No back-pressure; every strobe is accepted.
- value_o, output, VALUE_SIZE: current ramped duty; drives pwm_gen value_i. Registered.
- busy_o, output, 1: high while a ramp is in progress. Registered.
- done_o, output, 1: one-cycle pulse when value_o reaches the target. Registered.

## Operation
- Reset, when rst_i is high at an edge: state IDLE, value_o=0, target register=0, busy_o=0, done_o=0, both prescaler counters=0. Reset overrides every other input, including in mid-ramp.
- Tick generation:
  - us counter counts 0..CLOCK_FREQ_MHZ-1.
  - step counter counts 0..STEP_PERIOD_US-1 on each us wrap.
  - step_tick fires on the cycle where both counters wrap.
  - Both counters are held at 0 in IDLE.
- States:
  - IDLE: on target_valid_i, target_i>value_o → UP; target_i<value_o → DOWN; equal → stay IDLE with no busy and no done. Capturing from IDLE clears the counters.
  - UP, on step_tick: if target−value_o ≤ STEP_SIZE, then value_o←target, go to IDLE, pulse done_o. Otherwise value_o←value_o+STEP_SIZE.
  - DOWN, on step_tick: if value_o−target ≤ STEP_SIZE, then value_o←target, go to IDLE, pulse done_o. Otherwise value_o←value_o−STEP_SIZE.
- Arithmetic and overflow:
  - Differences are computed at VALUE_SIZE+1 bits.
  - value_o never wraps; the final step clamps exactly to target.
- Retarget during UP/DOWN:
  - The target register is updated.
  - Direction is re-evaluated against the current value_o: UP, DOWN, or, if equal, IDLE with a done pulse.
  - Counters are not cleared, so the step cadence continues uninterrupted.
- target_valid_i and step_tick in the same cycle: the step is applied toward the new target_i, not the old target register.
- busy_o is high in UP/DOWN and low in IDLE.

## Timing
- N = CLOCK_FREQ_MHZ × STEP_PERIOD_US cycles per step.
- Capture edge E (target_valid_i sampled high in IDLE): busy_o high from edge E.
- The first value_o change is at edge E+N; subsequent changes every N edges.
- A ramp of k steps completes at edge E+kN. At that edge:
  - value_o = target;
  - done_o is high for exactly one cycle;
  - busy_o falls.
- Back-to-back strobes: the last strobe's target wins.
- No combinational path from any input to any output.

## Test plan
Bench parameters: CLOCK_FREQ_MHZ=2, STEP_PERIOD_US=3, so N=6.
- Reset, then idle 50 cycles → value_o=0, busy_o=0, done_o never asserted.
- STEP_SIZE=1, target 5 at edge E:
  - value_o = 1,2,3,4,5 at E+6, E+12, E+18, E+24, E+30;
  - done_o pulses once at E+30;
  - busy_o high for edges E..E+29.
- STEP_SIZE=4, up then down:
  - 250→255: value_o 254 then 255, no wrap, done_o at the second step.
  - Then target 0 from 10: value_o 6, 2, 0.
- Retarget mid-ramp, STEP_SIZE=1:
  - target 200;
  - when value_o=3, strobe target 1 → direction flips; value_o 2, 1 on the continuing 6-cycle cadence;
  - single done_o pulse.
- Equal target and reset during a ramp:
  - Strobe target equal to value_o in IDLE → busy_o and done_o stay 0.
  - Assert rst_i mid-ramp → value_o=0, busy_o=0 on the next edge; no done_o pulse.
- Simultaneous strobe and step_tick, value_o=10, new target 12, STEP_SIZE=1 → value_o=11 at that edge; ramp continues to 12.
